axi_rd_arbiter: RTL and testbench
=================================

Name: axi_rd_arbiter

Overview:
Arbitrates the instruction-fetch and data-load read requesters (sram-like req/addr_ok/data_ok protocol) onto one AXI4 read address/data channel pair. It sits between Fetch/Excute and the AXI master port, beside the write path. It tracks outstanding reads per ID, routes R beats back by rid, blocks loads that hit an in-flight store, and prevents instruction-fetch starvation.

Parameters:
MAX_OUTSTANDING, 2, max un-returned reads per ID (1..7)
STARVE_LIMIT, 4, consecutive data grants allowed while inst_req waits (>=1)
INST_ID, 4'd0, arid/rid for fetch
DATA_ID, 4'd1, arid/rid for loads

Ports:
aclk  in  1  clock
aresetn  in  1  async active-low reset
inst_rd_req  in  1  fetch read request
inst_rd_addr  in  32  fetch byte address
inst_rd_size  in  2  0=byte,1=half,2=word
inst_rd_addr_ok  out  1  fetch request accepted this cycle
inst_rd_data_ok  out  1  fetch data returned this cycle
inst_rd_rdata  out  32  fetch data
data_rd_req  in  1  load request
data_rd_addr  in  32  load byte address
data_rd_size  in  2  as inst_rd_size
data_rd_addr_ok  out  1  load request accepted
data_rd_data_ok  out  1  load data returned
data_rd_rdata  out  32  load data
wr_inflight  in  1  store issued but B not yet received
wr_inflight_addr  in  32  address of that store
arid  out  4  AXI read ID
araddr  out  32  AXI address
arlen  out  8  constant 0
arsize  out  3  {1'b0,size}
arburst  out  2  constant 2'b01
arvalid  out  1  AR valid
arready  in  1  AR ready
rid  in  4  R ID
rdata  in  32  R data
rresp  in  2  R response
rlast  in  1  R last
rvalid  in  1  R valid
rready  out  1  R ready
bus_err  out  1  sticky: R beat with rresp!=0
id_err  out  1  sticky: R beat with unknown rid or rid whose count is 0

Behaviour:
- Reset (aresetn low, async): AR FSM=IDLE, arvalid=0, arid/araddr/arsize=0, all counters 0, bus_err=id_err=0, rready=0. Both *_addr_ok and *_data_ok read 0 during reset.
- AR FSM: IDLE (arvalid=0) and ISSUE (arvalid=1, payload held stable until arready).
- slot_free = (state==IDLE) | (state==ISSUE & arready).
- inst_ok = inst_rd_req & cnt_inst<MAX_OUTSTANDING.
- data_ok = data_rd_req & cnt_data<MAX_OUTSTANDING & ~(wr_inflight & data_rd_addr[31:2]==wr_inflight_addr[31:2]).
- Grant (combinational, only if slot_free):
  - data if data_ok & ~(inst_ok & starve_cnt==STARVE_LIMIT);
  - else inst if inst_ok.
- *_addr_ok = grant to that requester, same cycle as req (0 latency). At most one addr_ok per cycle.
- On grant: next edge loads arid/araddr/arsize, state=ISSUE. If slot_free but no grant: state=IDLE. Back-to-back issue is allowed when arready coincides with a new grant.
- starve_cnt: +1 on data grant while inst_rd_req=1, saturating at STARVE_LIMIT. Clears on inst grant or when inst_rd_req=0.
- Outstanding counters cnt_inst/cnt_data, width $clog2(MAX_OUTSTANDING+1):
  - +1 on grant;
  - -1 on rvalid&rready&rlast with matching rid;
  - both in one cycle leave the count unchanged;
  - never wrap. A decrement at 0 is suppressed and sets id_err.
- rready = 1 every cycle after reset release (registered, first high at the first edge after release). The block never backpressures R.
- inst_rd_data_ok = rvalid & rready & rid==INST_ID; data_rd_data_ok likewise with DATA_ID. rdata is passed through combinationally to both *_rdata.
- Responses return in AXI per-ID order. No reordering within an ID is required.
- Unknown rid: beat consumed, no data_ok, id_err set. Any rresp!=0: data_ok still asserted, bus_err set. Both error flags are sticky until reset.
- Reset mid-transaction: all state is dropped. The surrounding system resets together, so no stale R beats are expected.

Decomposition:
- Shared header (Defines.vh): AXI constants (BURST_INCR=2'b01, RESP_OKAY=2'b00), INST_ID/DATA_ID defaults, size encodings.
- One natural sub-module: rd_outstanding_cnt (saturating up/down counter with underflow flag), instantiated once per ID.

Test Plan:
1. Single fetch: inst_rd_req=1 addr 0x1C000000 size 2, arready=1 -> inst_rd_addr_ok same cycle; next cycle arvalid=1 arid=0 araddr=0x1C000000 arsize=3'b010 arlen=0. R beat rid=0 rdata=0xDEADBEEF -> inst_rd_data_ok=1, rdata passes through.
2. Simultaneous req, data addr 0x100 -> data granted first. Holding both reqs with arready=1 gives 4 data grants, then 1 inst grant (STARVE_LIMIT=4).
3. MAX_OUTSTANDING: 2 fetch grants, no R returned -> third inst_rd_addr_ok=0. One R beat rid=0 -> next request is granted.
4. Store hazard: wr_inflight=1 addr 0x2004, load to 0x2006 -> data_rd_addr_ok=0 and inst is still granted. Drop wr_inflight -> load granted.
5. arready held 0 for 5 cycles -> arvalid/araddr/arid stable and no further addr_ok. arready=1 with pending req -> back-to-back issue in the next cycle.
6. R beat rid=3 -> id_err=1, no data_ok. R beat rid=1 rresp=2'b10 -> data_rd_data_ok=1 and bus_err=1. Assert aresetn=0 -> both flags clear and arvalid=0 immediately.

Source files
------------

// File: rtl/axi_rd_arbiter_pkg.sv
// Shared constants and types for the AXI read arbiter.
package axi_rd_arbiter_pkg;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;

    localparam logic [3:0] INST_ID_DEF = 4'd0;
    localparam logic [3:0] DATA_ID_DEF = 4'd1;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } rd_size_e;

    typedef enum logic {
        AR_IDLE  = 1'b0,
        AR_ISSUE = 1'b1
    } ar_state_e;

    // Two byte addresses fall in the same 32-bit word.
    function automatic logic same_word(input logic [31:0] a, input logic [31:0] b);
        return a[31:2] == b[31:2];
    endfunction

endpackage

// File: rtl/axi_rd_arbiter_outstanding_cnt.sv
// Outstanding-read counter for one AXI ID: saturating up/down with underflow flag.
module rd_outstanding_cnt #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    localparam int unsigned W = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         underflow
);

    localparam logic [W-1:0] MAX_C = W'(MAX_OUTSTANDING);

    logic dec_eff;

    // A decrement at zero is dropped and reported instead.
    always_comb begin
        underflow = dec & (cnt == '0);
        dec_eff   = dec & (cnt != '0);
    end

    // Count register: simultaneous inc and dec cancel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            case ({inc, dec_eff})
                2'b10:   if (cnt < MAX_C) cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Arbitrates fetch and load read requesters onto a single AXI4 AR/R channel pair.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned STARVE_LIMIT    = 4,
    parameter logic [3:0]  INST_ID         = INST_ID_DEF,
    parameter logic [3:0]  DATA_ID         = DATA_ID_DEF
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        inst_rd_req,
    input  logic [31:0] inst_rd_addr,
    input  logic [1:0]  inst_rd_size,
    output logic        inst_rd_addr_ok,
    output logic        inst_rd_data_ok,
    output logic [31:0] inst_rd_rdata,
    input  logic        data_rd_req,
    input  logic [31:0] data_rd_addr,
    input  logic [1:0]  data_rd_size,
    output logic        data_rd_addr_ok,
    output logic        data_rd_data_ok,
    output logic [31:0] data_rd_rdata,
    input  logic        wr_inflight,
    input  logic [31:0] wr_inflight_addr,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic        bus_err,
    output logic        id_err
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] MAX_C    = CW'(MAX_OUTSTANDING);
    localparam logic [SW-1:0] STARVE_C = SW'(STARVE_LIMIT);

    ar_state_e     state, state_nxt;
    logic [CW-1:0] cnt_inst, cnt_data;
    logic [SW-1:0] starve_cnt;
    logic          uf_inst, uf_data;
    logic          slot_free, inst_elig, data_elig;
    logic          grant_inst, grant_data;
    logic          r_beat, r_inst, r_data, r_unknown;

    // R side: every beat is accepted; route by rid.
    always_comb begin
        r_beat    = rvalid & rready;
        r_inst    = r_beat & (rid == INST_ID);
        r_data    = r_beat & (rid == DATA_ID);
        r_unknown = r_beat & (rid != INST_ID) & (rid != DATA_ID);
    end

    assign inst_rd_data_ok = r_inst;
    assign data_rd_data_ok = r_data;
    assign inst_rd_rdata   = rdata;
    assign data_rd_rdata   = rdata;

    assign arvalid = (state == AR_ISSUE);
    assign arlen   = '0;
    assign arburst = BURST_INCR;

    // Grant selection and AR next state; reset gates grants so addr_ok stays low.
    always_comb begin
        state_nxt  = state;
        grant_inst = 1'b0;
        grant_data = 1'b0;
        slot_free  = (state == AR_IDLE) | ((state == AR_ISSUE) & arready);
        inst_elig  = inst_rd_req & (cnt_inst < MAX_C);
        data_elig  = data_rd_req & (cnt_data < MAX_C) &
                     ~(wr_inflight & same_word(data_rd_addr, wr_inflight_addr));
        if (slot_free & aresetn) begin
            if (data_elig & ~(inst_elig & (starve_cnt == STARVE_C))) begin
                grant_data = 1'b1;
            end else if (inst_elig) begin
                grant_inst = 1'b1;
            end
            state_nxt = (grant_inst | grant_data) ? AR_ISSUE : AR_IDLE;
        end
    end

    assign inst_rd_addr_ok = grant_inst;
    assign data_rd_addr_ok = grant_data;

    // AR state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= AR_IDLE;
        else          state <= state_nxt;
    end

    // AR payload: loaded on grant, otherwise held until the next grant.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            arid   <= '0;
            araddr <= '0;
            arsize <= '0;
        end else if (grant_data) begin
            arid   <= DATA_ID;
            araddr <= data_rd_addr;
            arsize <= {1'b0, data_rd_size};
        end else if (grant_inst) begin
            arid   <= INST_ID;
            araddr <= inst_rd_addr;
            arsize <= {1'b0, inst_rd_size};
        end
    end

    // Consecutive data grants while fetch waits; saturates at the limit.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            starve_cnt <= '0;
        end else if (!inst_rd_req || grant_inst) begin
            starve_cnt <= '0;
        end else if (grant_data && starve_cnt < STARVE_C) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // rready rises at the first edge after reset release and stays high.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) rready <= 1'b0;
        else          rready <= 1'b1;
    end

    // Sticky error flags.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bus_err <= 1'b0;
            id_err  <= 1'b0;
        end else begin
            if (r_beat && rresp != RESP_OKAY)        bus_err <= 1'b1;
            if (r_unknown || uf_inst || uf_data)     id_err  <= 1'b1;
        end
    end

    rd_outstanding_cnt #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_cnt_inst (
        .clk       (aclk),
        .rst_n     (aresetn),
        .inc       (grant_inst),
        .dec       (r_inst & rlast),
        .cnt       (cnt_inst),
        .underflow (uf_inst)
    );

    rd_outstanding_cnt #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_cnt_data (
        .clk       (aclk),
        .rst_n     (aresetn),
        .inc       (grant_data),
        .dec       (r_data & rlast),
        .cnt       (cnt_data),
        .underflow (uf_data)
    );

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: directed plan steps plus random traffic.
module tb_axi_rd_arbiter;

    localparam int MAXO = 2;
    localparam int SLIM = 4;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        inst_rd_req, data_rd_req;
    logic [31:0] inst_rd_addr, data_rd_addr;
    logic [1:0]  inst_rd_size, data_rd_size;
    logic        inst_rd_addr_ok, inst_rd_data_ok, data_rd_addr_ok, data_rd_data_ok;
    logic [31:0] inst_rd_rdata, data_rd_rdata;
    logic        wr_inflight;
    logic [31:0] wr_inflight_addr;
    logic [3:0]  arid, rid;
    logic [31:0] araddr, rdata;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, rresp;
    logic        arvalid, arready, rlast, rvalid, rready, bus_err, id_err;

    always #5 aclk = ~aclk;

    axi_rd_arbiter #(
        .MAX_OUTSTANDING (MAXO),
        .STARVE_LIMIT    (SLIM),
        .INST_ID         (4'd0),
        .DATA_ID         (4'd1)
    ) dut (
        .aclk (aclk), .aresetn (aresetn),
        .inst_rd_req (inst_rd_req), .inst_rd_addr (inst_rd_addr), .inst_rd_size (inst_rd_size),
        .inst_rd_addr_ok (inst_rd_addr_ok), .inst_rd_data_ok (inst_rd_data_ok), .inst_rd_rdata (inst_rd_rdata),
        .data_rd_req (data_rd_req), .data_rd_addr (data_rd_addr), .data_rd_size (data_rd_size),
        .data_rd_addr_ok (data_rd_addr_ok), .data_rd_data_ok (data_rd_data_ok), .data_rd_rdata (data_rd_rdata),
        .wr_inflight (wr_inflight), .wr_inflight_addr (wr_inflight_addr),
        .arid (arid), .araddr (araddr), .arlen (arlen), .arsize (arsize), .arburst (arburst),
        .arvalid (arvalid), .arready (arready),
        .rid (rid), .rdata (rdata), .rresp (rresp), .rlast (rlast), .rvalid (rvalid), .rready (rready),
        .bus_err (bus_err), .id_err (id_err)
    );

    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    int unsigned n_fail = 0;

    // Reference model: outstanding reads per ID, pending AR slot, starvation run.
    int          m_cnt [2];
    bit          m_pend;
    logic [3:0]  m_arid;
    logic [31:0] m_araddr;
    logic [2:0]  m_arsize;
    int          m_starve;
    bit          m_bus_err, m_id_err, m_rready;
    bit          e_gi, e_gd, e_beat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt[0] = 0; m_cnt[1] = 0;
        m_pend = 0; m_arid = '0; m_araddr = '0; m_arsize = '0;
        m_starve = 0; m_bus_err = 0; m_id_err = 0; m_rready = 0;
    endtask

    task automatic model_comb();
        bit slot, iok, dok, hazard;
        slot   = !m_pend || arready;
        iok    = inst_rd_req && m_cnt[0] < MAXO;
        hazard = wr_inflight && ((data_rd_addr >> 2) == (wr_inflight_addr >> 2));
        dok    = data_rd_req && m_cnt[1] < MAXO && !hazard;
        e_gd   = aresetn && slot && dok && !(iok && m_starve == SLIM);
        e_gi   = aresetn && slot && iok && !e_gd;
        e_beat = rvalid && m_rready;
    endtask

    task automatic model_edge();
        int inc, dec;
        if (!aresetn) begin
            model_reset();
            return;
        end
        if (!m_pend || arready) begin
            m_pend = e_gi || e_gd;
            if (e_gd) begin
                m_arid = 4'd1; m_araddr = data_rd_addr; m_arsize = {1'b0, data_rd_size};
            end else if (e_gi) begin
                m_arid = 4'd0; m_araddr = inst_rd_addr; m_arsize = {1'b0, inst_rd_size};
            end
        end
        for (int k = 0; k < 2; k++) begin
            inc = (k == 0) ? int'(e_gi) : int'(e_gd);
            dec = (e_beat && rlast && rid == k) ? 1 : 0;
            if (dec == 1 && m_cnt[k] == 0) begin
                m_id_err = 1;
                dec = 0;
            end
            m_cnt[k] = m_cnt[k] + inc - dec;
        end
        if (e_beat && rid > 1) m_id_err = 1;
        if (e_beat && rresp != 2'b00) m_bus_err = 1;
        if (!inst_rd_req || e_gi) m_starve = 0;
        else if (e_gd && m_starve < SLIM) m_starve++;
        m_rready = 1;
    endtask

    task automatic check_all();
        chk("inst_addr_ok", inst_rd_addr_ok, e_gi);
        chk("data_addr_ok", data_rd_addr_ok, e_gd);
        chk("inst_data_ok", inst_rd_data_ok, e_beat && rid == 4'd0);
        chk("data_data_ok", data_rd_data_ok, e_beat && rid == 4'd1);
        chk("inst_rdata", inst_rd_rdata, rdata);
        chk("data_rdata", data_rd_rdata, rdata);
        chk("arvalid", arvalid, m_pend);
        chk("arid", arid, m_arid);
        chk("araddr", araddr, m_araddr);
        chk("arsize", arsize, m_arsize);
        chk("arlen", arlen, 32'd0);
        chk("arburst", arburst, 32'd1);
        chk("rready", rready, m_rready);
        chk("bus_err", bus_err, m_bus_err);
        chk("id_err", id_err, m_id_err);
    endtask

    task automatic settle();
        #1;
        model_comb();
        check_all();
    endtask

    task automatic clk_edge();
        @(posedge aclk);
        model_edge();
        @(negedge aclk);
    endtask

    task automatic cycle();
        settle();
        clk_edge();
    endtask

    task automatic drain();
        for (int g = 0; g < 20 && (m_cnt[0] > 0 || m_cnt[1] > 0); g++) begin
            rvalid = 1; rlast = 1; rresp = 2'b00; rdata = $urandom;
            rid = (m_cnt[0] > 0) ? 4'd0 : 4'd1;
            cycle();
        end
        rvalid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int gseq [5];
        int prev;
        logic [31:0] hold_addr;

        aresetn = 0;
        inst_rd_req = 0; inst_rd_addr = '0; inst_rd_size = 2'd2;
        data_rd_req = 0; data_rd_addr = '0; data_rd_size = 2'd2;
        wr_inflight = 0; wr_inflight_addr = '0; arready = 0;
        rid = '0; rdata = '0; rresp = '0; rlast = 0; rvalid = 0;
        model_reset();
        @(negedge aclk);

        // Reset: requests must not be acknowledged.
        inst_rd_req = 1; data_rd_req = 1;
        settle();
        chk("rst_inst_addr_ok", inst_rd_addr_ok, 32'd0);
        chk("rst_data_addr_ok", data_rd_addr_ok, 32'd0);
        clk_edge();
        inst_rd_req = 0; data_rd_req = 0;
        aresetn = 1;
        cycle();
        cycle();

        // 1: single fetch.
        inst_rd_req = 1; inst_rd_addr = 32'h1C00_0000; inst_rd_size = 2'd2; arready = 1;
        settle();
        chk("t1_addr_ok", inst_rd_addr_ok, 32'd1);
        clk_edge();
        inst_rd_req = 0;
        settle();
        chk("t1_arvalid", arvalid, 32'd1);
        chk("t1_arid", arid, 32'd0);
        chk("t1_araddr", araddr, 32'h1C00_0000);
        chk("t1_arsize", arsize, 32'd2);
        clk_edge();
        rvalid = 1; rid = 4'd0; rlast = 1; rdata = 32'hDEAD_BEEF;
        settle();
        chk("t1_data_ok", inst_rd_data_ok, 32'd1);
        chk("t1_rdata", inst_rd_rdata, 32'hDEAD_BEEF);
        clk_edge();
        rvalid = 0;
        drain();

        // 2: starvation guard, 4 data grants then one fetch grant.
        inst_rd_req = 1; inst_rd_addr = 32'h1C00_0004;
        data_rd_req = 1; data_rd_addr = 32'h0000_0100; arready = 1;
        prev = -1;
        for (int i = 0; i < 5; i++) begin
            rvalid = (prev >= 0); rlast = 1; rresp = 0; rdata = $urandom;
            rid = (prev >= 0) ? 4'(prev) : 4'd0;
            settle();
            gseq[i] = inst_rd_addr_ok ? 0 : (data_rd_addr_ok ? 1 : 2);
            prev = (gseq[i] == 2) ? -1 : gseq[i];
            clk_edge();
        end
        for (int i = 0; i < 5; i++) chk($sformatf("t2_grant%0d", i), gseq[i], (i < 4) ? 32'd1 : 32'd0);
        inst_rd_req = 0; data_rd_req = 0; rvalid = 0;
        drain();

        // 3: outstanding limit per ID.
        inst_rd_req = 1; inst_rd_addr = 32'h1C00_0040;
        cycle();
        cycle();
        settle();
        chk("t3_blocked", inst_rd_addr_ok, 32'd0);
        clk_edge();
        rvalid = 1; rid = 4'd0; rlast = 1; rdata = $urandom;
        settle();
        chk("t3_blocked_beat", inst_rd_addr_ok, 32'd0);
        clk_edge();
        rvalid = 0;
        settle();
        chk("t3_resume", inst_rd_addr_ok, 32'd1);
        clk_edge();
        inst_rd_req = 0;
        drain();

        // 4: load blocked by in-flight store to the same word.
        wr_inflight = 1; wr_inflight_addr = 32'h0000_2004;
        data_rd_req = 1; data_rd_addr = 32'h0000_2006; inst_rd_req = 1;
        settle();
        chk("t4_data_blocked", data_rd_addr_ok, 32'd0);
        chk("t4_inst_granted", inst_rd_addr_ok, 32'd1);
        clk_edge();
        inst_rd_req = 0; wr_inflight = 0;
        settle();
        chk("t4_data_granted", data_rd_addr_ok, 32'd1);
        clk_edge();
        data_rd_req = 0;
        drain();

        // 5: AR stall holds payload, then back-to-back issue.
        arready = 0; inst_rd_req = 1; inst_rd_addr = 32'h1C00_0100;
        cycle();
        hold_addr = 32'h1C00_0100;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("t5_no_addr_ok", inst_rd_addr_ok, 32'd0);
            chk("t5_arvalid", arvalid, 32'd1);
            chk("t5_araddr", araddr, hold_addr);
            chk("t5_arid", arid, 32'd0);
            clk_edge();
        end
        arready = 1; inst_rd_addr = 32'h1C00_0200;
        settle();
        chk("t5_b2b_addr_ok", inst_rd_addr_ok, 32'd1);
        clk_edge();
        inst_rd_req = 0;
        settle();
        chk("t5_b2b_arvalid", arvalid, 32'd1);
        chk("t5_b2b_araddr", araddr, 32'h1C00_0200);
        clk_edge();
        drain();

        // 6: error flags and asynchronous reset.
        rvalid = 1; rid = 4'd3; rlast = 1; rresp = 0; rdata = $urandom;
        settle();
        chk("t6_unk_inst_ok", inst_rd_data_ok, 32'd0);
        chk("t6_unk_data_ok", data_rd_data_ok, 32'd0);
        clk_edge();
        rvalid = 0;
        settle();
        chk("t6_id_err", id_err, 32'd1);
        clk_edge();
        rvalid = 1; rid = 4'd1; rresp = 2'b10; rdata = 32'h1234_5678;
        settle();
        chk("t6_slverr_data_ok", data_rd_data_ok, 32'd1);
        chk("t6_slverr_rdata", data_rd_rdata, 32'h1234_5678);
        clk_edge();
        rvalid = 0; rresp = 0;
        settle();
        chk("t6_bus_err", bus_err, 32'd1);
        clk_edge();
        arready = 0; data_rd_req = 1; data_rd_addr = 32'h0000_0300;
        cycle();
        data_rd_req = 0;
        #2;
        aresetn = 0;
        #1;
        chk("t6_rst_bus_err", bus_err, 32'd0);
        chk("t6_rst_id_err", id_err, 32'd0);
        chk("t6_rst_arvalid", arvalid, 32'd0);
        chk("t6_rst_rready", rready, 32'd0);
        model_reset();
        @(negedge aclk);
        cycle();
        aresetn = 1;
        cycle();
        cycle();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            inst_rd_req  = ($urandom_range(0, 3) != 0);
            data_rd_req  = ($urandom_range(0, 3) != 0);
            inst_rd_addr = $urandom;
            data_rd_addr = $urandom & 32'h0000_3FFF;
            inst_rd_size = 2'($urandom_range(0, 2));
            data_rd_size = 2'($urandom_range(0, 2));
            wr_inflight  = $urandom_range(0, 1);
            wr_inflight_addr = ($urandom_range(0, 1) != 0) ? (data_rd_addr ^ 32'($urandom_range(0, 7)))
                                                            : ($urandom & 32'h0000_3FFF);
            arready = $urandom_range(0, 1);
            rdata   = $urandom;
            rlast   = 1;
            rresp   = ($urandom_range(0, 31) == 0) ? 2'b10 : 2'b00;
            rvalid  = 0;
            rid     = 4'd0;
            if ($urandom_range(0, 1) != 0) begin
                if (m_cnt[0] > 0 && (m_cnt[1] == 0 || $urandom_range(0, 1) != 0)) begin
                    rvalid = 1; rid = 4'd0;
                end else if (m_cnt[1] > 0) begin
                    rvalid = 1; rid = 4'd1;
                end
            end
            if ($urandom_range(0, 63) == 0) begin
                rvalid = 1; rid = 4'($urandom_range(2, 15));
            end
            cycle();
        end
        inst_rd_req = 0; data_rd_req = 0; wr_inflight = 0; arready = 1;
        drain();
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
